lsu: RTL and testbench

- Memory-access stage directly downstream of the EXU ALU.
- Consumes the ALU result (arithmetic value or effective address), load/store type flags, store data and rd info.
- Drives a single-port data-memory bus with a req/gnt/rvalid handshake, then presents registered results to writeback.
- Stalls the pipeline while a memory access is outstanding.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_if.sv | 24 ++
 rtl/lsu_load_align.sv | 34 +++
 rtl/lsu.sv | 229 ++++++++++++++++++++++
 tb/tb_lsu.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: load/store type encodings,
// FSM states, byte-enable constants and small decode helpers.
package lsu_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int XREG_ADDRWIDTH = 5;

    // Load type encodings (one-hot, zero = no load)
    localparam logic [4:0] NO_LOAD = 5'b00000;
    localparam logic [4:0] LOAD_B  = 5'b00001;
    localparam logic [4:0] LOAD_H  = 5'b00010;
    localparam logic [4:0] LOAD_W  = 5'b00100;
    localparam logic [4:0] LOAD_BU = 5'b01000;
    localparam logic [4:0] LOAD_HU = 5'b10000;

    // Store type encodings (one-hot, zero = no store)
    localparam logic [2:0] NO_STORE = 3'b000;
    localparam logic [2:0] STORE_B  = 3'b001;
    localparam logic [2:0] STORE_H  = 3'b010;
    localparam logic [2:0] STORE_W  = 3'b100;

    localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;

    // Byte-enable patterns before lane shifting
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } acc_size_e;

    function automatic logic is_load(input logic [4:0] flag);
        return (flag == LOAD_B) || (flag == LOAD_H) || (flag == LOAD_W) ||
               (flag == LOAD_BU) || (flag == LOAD_HU);
    endfunction

    function automatic logic is_store(input logic [2:0] flag);
        return (flag == STORE_B) || (flag == STORE_H) || (flag == STORE_W);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Single-port data-memory bus with req/gnt/rvalid handshake.
// master = LSU side, slave = memory side.
interface lsu_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the
// returned word and sign- or zero-extends it according to the load type.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [4:0]      load_type,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
    assign half_v = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Extend the selected lane to the register width
    always_comb begin
        // NOTE: default first so every path assigns data; otherwise a latch is inferred.
        data = '0;
        case (load_type)
            LOAD_B:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
            LOAD_BU: data = {{(XLEN-8){1'b0}}, byte_v};
            LOAD_H:  data = {{(XLEN-16){half_v[15]}}, half_v};
            LOAD_HU: data = {{(XLEN-16){1'b0}}, half_v};
            LOAD_W:  data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: memory-access stage after the EXU ALU. Non-memory
// instructions pass through to writeback in one cycle; loads/stores are
// latched, issued on the data bus and retired with a registered result.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses instead of forcing the low address bits to zero.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = XREG_ADDRWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [4:0]        load_flag_in,
    input  logic [2:0]        store_flag_in,
    input  logic [XLEN-1:0]   store_data_in,
    input  logic              rd_en_in,
    input  logic [REG_AW-1:0] rd_addr_in,
    lsu_if.master             mem,
    output logic              wb_valid_out,
    output logic              wb_en_out,
    output logic [REG_AW-1:0] wb_addr_out,
    output logic [XLEN-1:0]   wb_data_out,
    output logic              stall_out,
    output logic              misalign_out
);

    lsu_state_e state, state_next;

    // Latched access
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic [4:0]        ld_type_q;
    logic              rd_en_q;
    logic [REG_AW-1:0] rd_addr_q;

    // Incoming access decode
    logic              ld_hit;
    logic              mem_op;
    logic              trap;
    logic              accept;
    acc_size_e         acc_size;
    logic [1:0]        acc_lo;
    logic [3:0]        acc_be;
    logic [XLEN-1:0]   acc_wdata;
    logic [XLEN-1:0]   load_data;

    assign ld_hit = is_load(load_flag_in);
    assign mem_op = ld_hit || is_store(store_flag_in);

    // Access size; a valid load flag takes priority over a store flag
    always_comb begin
        acc_size = SIZE_W;
        if (ld_hit) begin
            case (load_flag_in)
                LOAD_B, LOAD_BU: acc_size = SIZE_B;
                LOAD_H, LOAD_HU: acc_size = SIZE_H;
                default:         acc_size = SIZE_W;
            endcase
        end else begin
            case (store_flag_in)
                STORE_B: acc_size = SIZE_B;
                STORE_H: acc_size = SIZE_H;
                default: acc_size = SIZE_W;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_q;

    assign misaligned = ((acc_size == SIZE_H) && alu_result_in[0]) ||
                        ((acc_size == SIZE_W) && (alu_result_in[1:0] != 2'b00));
    assign trap       = (state == LSU_IDLE) && ex_valid_in && mem_op && misaligned;
    assign acc_lo     = alu_result_in[1:0];

    // One-cycle pulse in the cycle after a trapped access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= trap;
    end

    assign misalign_out = misalign_q;
`else
    assign trap = 1'b0;

    // Low address bits below the access size are forced to zero
    always_comb begin
        acc_lo = alu_result_in[1:0];
        case (acc_size)
            SIZE_H:  acc_lo = {alu_result_in[1], 1'b0};
            SIZE_W:  acc_lo = 2'b00;
            default: acc_lo = alu_result_in[1:0];
        endcase
    end

    assign misalign_out = 1'b0;
`endif

    // Byte enables and lane-replicated write data for the incoming access
    always_comb begin
        acc_be    = BE_WORD;
        acc_wdata = store_data_in;
        case (acc_size)
            SIZE_B: begin
                acc_be    = BE_BYTE << acc_lo;
                acc_wdata = {4{store_data_in[7:0]}};
            end
            SIZE_H: begin
                acc_be    = BE_HALF << {acc_lo[1], 1'b0};
                acc_wdata = {2{store_data_in[15:0]}};
            end
            default: begin
                acc_be    = BE_WORD;
                acc_wdata = store_data_in;
            end
        endcase
    end

    assign accept = (state == LSU_IDLE) && ex_valid_in && mem_op && !trap;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state <= LSU_IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            LSU_IDLE: if (accept) state_next = LSU_REQ;
            LSU_REQ:  if (mem.gnt) state_next = we_q ? LSU_IDLE : LSU_WAIT;
            LSU_WAIT: if (mem.rvalid) state_next = LSU_IDLE;
            default:  state_next = LSU_IDLE;
        endcase
    end

    // FSM outputs; reset forces both low immediately
    always_comb begin
        mem.req   = 1'b0;
        stall_out = 1'b0;
        if (!rst) begin
            mem.req   = (state == LSU_REQ);
            stall_out = (state != LSU_IDLE) || accept;
        end
    end

    // Capture the accepted access; held stable until the access retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            ld_type_q <= NO_LOAD;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else if (accept) begin
            addr_q    <= {alu_result_in[XLEN-1:2], acc_lo};
            wdata_q   <= acc_wdata;
            be_q      <= acc_be;
            we_q      <= !ld_hit;
            ld_type_q <= ld_hit ? load_flag_in : NO_LOAD;
            rd_en_q   <= rd_en_in;
            rd_addr_q <= rd_addr_in;
        end
    end

    assign mem.we    = we_q;
    assign mem.addr  = {addr_q[XLEN-1:2], 2'b00};
    assign mem.be    = be_q;
    assign mem.wdata = wdata_q;

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata     (mem.rdata),
        .addr_lo   (addr_q[1:0]),
        .load_type (ld_type_q),
        .data      (load_data)
    );

    // Writeback slot: single-cycle valid pulse per retired instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_out <= 1'b0;
            wb_en_out    <= 1'b0;
            wb_addr_out  <= '0;
            wb_data_out  <= '0;
        end else begin
            wb_valid_out <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (ex_valid_in && !mem_op) begin
                        wb_valid_out <= 1'b1;
                        wb_en_out    <= rd_en_in;
                        wb_addr_out  <= rd_addr_in;
                        wb_data_out  <= alu_result_in;
                    end else if (trap) begin
                        wb_valid_out <= 1'b1;
                        wb_en_out    <= 1'b0;
                        wb_addr_out  <= rd_addr_in;
                    end
                end
                LSU_REQ: begin
                    if (mem.gnt && we_q) begin
                        wb_valid_out <= 1'b1;
                        wb_en_out    <= 1'b0;
                    end
                end
                LSU_WAIT: begin
                    if (mem.rvalid) begin
                        wb_valid_out <= 1'b1;
                        wb_en_out    <= rd_en_q;
                        wb_addr_out  <= rd_addr_q;
                        wb_data_out  <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge (registered) or 1 time unit after an input change (combinational).
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic [4:0]  load_flag;
    logic [2:0]  store_flag;
    logic [31:0] store_data;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        misalign;

    int tests_run    = 0;
    int tests_failed = 0;

    lsu_if #(.XLEN(32)) mem_bus ();

    lsu #(.XLEN(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid_in   (ex_valid),
        .alu_result_in (alu_result),
        .load_flag_in  (load_flag),
        .store_flag_in (store_flag),
        .store_data_in (store_data),
        .rd_en_in      (rd_en),
        .rd_addr_in    (rd_addr),
        .mem           (mem_bus),
        .wb_valid_out  (wb_valid),
        .wb_en_out     (wb_en),
        .wb_addr_out   (wb_addr),
        .wb_data_out   (wb_data),
        .stall_out     (stall),
        .misalign_out  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid   = 1'b0;
        load_flag  = NO_LOAD;
        store_flag = NO_STORE;
    endtask

    // Issue one load/store and follow it through the bus handshake to writeback
    task automatic run_access(
        input string       tag,
        input logic [31:0] addr,
        input logic [4:0]  ld,
        input logic [2:0]  st,
        input logic [31:0] sdata,
        input logic [4:0]  rd,
        input int          gnt_dly,
        input int          rv_dly,
        input logic [31:0] rdata,
        input logic [31:0] exp_addr,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata,
        input logic        exp_we,
        input logic [31:0] exp_wb_data
    );
        int req_cycles;
        req_cycles = 0;
        @(negedge clk);
        ex_valid   = 1'b1;
        alu_result = addr;
        load_flag  = ld;
        store_flag = st;
        store_data = sdata;
        rd_en      = 1'b1;
        rd_addr    = rd;
        #1;
        check({tag, ".stall_accept"}, 32'(stall), 32'd1);
        check({tag, ".req_accept"}, 32'(mem_bus.req), 32'd0);
        @(negedge clk);
        idle_inputs();
        check({tag, ".addr"}, mem_bus.addr, exp_addr);
        check({tag, ".be"}, 32'(mem_bus.be), 32'(exp_be));
        check({tag, ".we"}, 32'(mem_bus.we), 32'(exp_we));
        check({tag, ".wb_valid_req"}, 32'(wb_valid), 32'd0);
        if (exp_we) check({tag, ".wdata"}, mem_bus.wdata, exp_wdata);
        for (int i = 0; i < gnt_dly; i++) begin
            if (mem_bus.req) req_cycles++;
            check({tag, ".stall_req"}, 32'(stall), 32'd1);
            @(negedge clk);
        end
        mem_bus.gnt = 1'b1;
        #1;
        if (mem_bus.req) req_cycles++;
        check({tag, ".addr_at_gnt"}, mem_bus.addr, exp_addr);
        @(negedge clk);
        mem_bus.gnt = 1'b0;
        check({tag, ".req_cycles"}, 32'(req_cycles), 32'(gnt_dly + 1));
        check({tag, ".req_after_gnt"}, 32'(mem_bus.req), 32'd0);
        if (!exp_we) begin
            for (int i = 1; i < rv_dly; i++) begin
                check({tag, ".stall_wait"}, 32'(stall), 32'd1);
                check({tag, ".wb_valid_wait"}, 32'(wb_valid), 32'd0);
                @(negedge clk);
            end
            mem_bus.rvalid = 1'b1;
            mem_bus.rdata  = rdata;
            #1;
            check({tag, ".stall_rvalid"}, 32'(stall), 32'd1);
            @(negedge clk);
            mem_bus.rvalid = 1'b0;
            mem_bus.rdata  = 32'h0;
        end
        check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, ".wb_en"}, 32'(wb_en), 32'(!exp_we));
        check({tag, ".stall_wb"}, 32'(stall), 32'd0);
        if (!exp_we) begin
            check({tag, ".wb_addr"}, 32'(wb_addr), 32'(rd));
            check({tag, ".wb_data"}, wb_data, exp_wb_data);
        end
        @(negedge clk);
        check({tag, ".wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        alu_result     = 32'h0;
        store_data     = 32'h0;
        rd_en          = 1'b0;
        rd_addr        = 5'd0;
        mem_bus.gnt    = 1'b0;
        mem_bus.rvalid = 1'b0;
        mem_bus.rdata  = 32'h0;
        idle_inputs();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst.req", 32'(mem_bus.req), 32'd0);
        check("rst.we", 32'(mem_bus.we), 32'd0);
        check("rst.addr", mem_bus.addr, 32'd0);
        check("rst.be", 32'(mem_bus.be), 32'd0);
        check("rst.wdata", mem_bus.wdata, 32'd0);
        check("rst.wb_valid", 32'(wb_valid), 32'd0);
        check("rst.wb_data", wb_data, 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.misalign", 32'(misalign), 32'd0);
        rst = 1'b0;

        // ALU passthrough
        @(negedge clk);
        ex_valid   = 1'b1;
        alu_result = 32'h0000_1234;
        rd_en      = 1'b1;
        rd_addr    = 5'd5;
        #1;
        check("add.stall", 32'(stall), 32'd0);
        @(negedge clk);
        idle_inputs();
        check("add.wb_valid", 32'(wb_valid), 32'd1);
        check("add.wb_en", 32'(wb_en), 32'd1);
        check("add.wb_addr", 32'(wb_addr), 32'd5);
        check("add.wb_data", wb_data, 32'h0000_1234);
        check("add.stall_wb", 32'(stall), 32'd0);
        check("add.req", 32'(mem_bus.req), 32'd0);
        @(negedge clk);
        check("add.wb_pulse", 32'(wb_valid), 32'd0);

        // Stores
        run_access("sb", 32'h0000_1003, NO_LOAD, STORE_B, 32'h0000_00A5, 5'd0, 2, 0, 32'h0,
                   32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1'b1, 32'h0);
        run_access("sh", 32'h0000_1002, NO_LOAD, STORE_H, 32'h1234_BEEF, 5'd0, 0, 0, 32'h0,
                   32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0);

        // Loads
        run_access("lb", 32'h0000_2001, LOAD_B, NO_STORE, 32'h0, 5'd7, 0, 3, 32'h1234_80FF,
                   32'h0000_2000, 4'b0010, 32'h0, 1'b0, 32'hFFFF_FF80);
        run_access("lhu", 32'h0000_2002, LOAD_HU, NO_STORE, 32'h0, 5'd8, 1, 1, 32'h8001_0000,
                   32'h0000_2000, 4'b1100, 32'h0, 1'b0, 32'h0000_8001);
        run_access("lh", 32'h0000_2002, LOAD_H, NO_STORE, 32'h0, 5'd9, 0, 2, 32'h8001_0000,
                   32'h0000_2000, 4'b1100, 32'h0, 1'b0, 32'hFFFF_8001);
        run_access("lw", 32'h0000_2000, LOAD_W, NO_STORE, 32'h0, 5'd10, 0, 1, 32'hDEAD_BEEF,
                   32'h0000_2000, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF);
        run_access("lbu", 32'h0000_2003, LOAD_BU, NO_STORE, 32'h0, 5'd11, 0, 1, 32'hAB00_0000,
                   32'h0000_2000, 4'b1000, 32'h0, 1'b0, 32'h0000_00AB);
        run_access("ld_wins", 32'h0000_4000, LOAD_W, STORE_W, 32'h5555_5555, 5'd12, 0, 1, 32'h1357_2468,
                   32'h0000_4000, 4'b1111, 32'h0, 1'b0, 32'h1357_2468);

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned word load traps without touching the bus
        @(negedge clk);
        ex_valid   = 1'b1;
        alu_result = 32'h0000_2002;
        load_flag  = LOAD_W;
        rd_en      = 1'b1;
        rd_addr    = 5'd13;
        #1;
        check("mis.stall", 32'(stall), 32'd0);
        @(negedge clk);
        idle_inputs();
        check("mis.req", 32'(mem_bus.req), 32'd0);
        check("mis.misalign", 32'(misalign), 32'd1);
        check("mis.wb_valid", 32'(wb_valid), 32'd1);
        check("mis.wb_en", 32'(wb_en), 32'd0);
        @(negedge clk);
        check("mis.pulse", 32'(misalign), 32'd0);
        check("mis.wb_pulse", 32'(wb_valid), 32'd0);
`else
        // Misaligned word load proceeds with the low address bits cleared
        run_access("mis", 32'h0000_2002, LOAD_W, NO_STORE, 32'h0, 5'd13, 0, 1, 32'hCAFE_F00D,
                   32'h0000_2000, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D);
        check("mis.misalign", 32'(misalign), 32'd0);
`endif

        // Reset during REQ drops the request immediately
        @(negedge clk);
        ex_valid   = 1'b1;
        alu_result = 32'h0000_5000;
        store_flag = STORE_W;
        store_data = 32'h0BAD_0BAD;
        @(negedge clk);
        idle_inputs();
        check("rst_req.req_before", 32'(mem_bus.req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_req.req", 32'(mem_bus.req), 32'd0);
        check("rst_req.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during WAIT abandons the load even if rvalid arrives
        @(negedge clk);
        ex_valid   = 1'b1;
        alu_result = 32'h0000_2000;
        load_flag  = LOAD_W;
        rd_addr    = 5'd14;
        @(negedge clk);
        idle_inputs();
        mem_bus.gnt = 1'b1;
        @(negedge clk);
        mem_bus.gnt = 1'b0;
        check("rst_wait.stall_before", 32'(stall), 32'd1);
        rst            = 1'b1;
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = 32'hFFFF_FFFF;
        #1;
        check("rst_wait.req", 32'(mem_bus.req), 32'd0);
        check("rst_wait.stall", 32'(stall), 32'd0);
        check("rst_wait.wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("rst_wait.wb_valid_edge", 32'(wb_valid), 32'd0);
        rst            = 1'b0;
        mem_bus.rvalid = 1'b0;
        mem_bus.rdata  = 32'h0;

        // Normal store after reset release
        run_access("sw_post_rst", 32'h0000_3000, NO_LOAD, STORE_W, 32'h1122_3344, 5'd0, 1, 0, 32'h0,
                   32'h0000_3000, 4'b1111, 32'h1122_3344, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
